acc_sequencer: RTL and testbench

//   Fetch/execute controller for the 8-bit accumulator ALU. It fetches 16-bit instructions over a valid/ready port
//   and owns the accumulator, carry flag and a small register file. It drives the ALU operand/op inputs and commits
//   the ALU results. It sits between the program store and the combinational ALU datapath.

---
 rtl/acc_pkg.sv | 40 ++++
 rtl/acc_regfile.sv | 26 ++
 rtl/acc_sequencer.sv | 110 +++++++++++
 tb/tb_acc_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator sequencer: opcodes, instruction field positions, FSM states.
package acc_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_OR    = 4'h2,
        OP_AND   = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOT   = 4'h5,
        OP_LD    = 4'h6,
        OP_ST    = 4'h7,
        OP_CLC   = 4'h8,
        OP_HALT  = 4'h9,
        OP_JMP   = 4'hA,
        OP_JC    = 4'hB,
        OP_NOP_C = 4'hC,
        OP_NOP_D = 4'hD,
        OP_NOP_E = 4'hE,
        OP_NOP_F = 4'hF
    } op_e;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int IMM_BIT = 11;

    // Op F makes the ALU output 0, so this is a harmless power-up instruction
    localparam logic [15:0] NOP_INSTR = 16'hF000;

    typedef logic [1:0] state_e;
    localparam state_e ST_IDLE  = 2'd0;
    localparam state_e ST_FETCH = 2'd1;
    localparam state_e ST_EXEC  = 2'd2;
    localparam state_e ST_HALT  = 2'd3;

    function automatic logic is_alu_op(op_e op);
        return op <= OP_LD;
    endfunction

endpackage

// File: rtl/acc_regfile.sv
// Small register file: one combinational read port, one synchronous write port, sync reset to zero.
module acc_regfile #(
    parameter int AW = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data
);

    logic [7:0] regs [2**AW];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 2**AW; i++) regs[i] <= 8'h00;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs[rd_addr];

endmodule

// File: rtl/acc_sequencer.sv
// Fetch/execute controller for the 8-bit accumulator ALU.
// Build option: define ACC_SEQ_JUMP_EN to make ops A (JMP) and B (JC) load the PC.
//
// state | meaning
// IDLE  | waiting for IN_START
// FETCH | READY high, waiting for a valid instruction
// EXEC  | one cycle, commit ALU result / ST / CLC / jump
// HALT  | stopped by op 9, leaves only on RST
module acc_sequencer
    import acc_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int REG_AW = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_START,
    input  logic [15:0]     IN_INSTR,
    input  logic            IN_INSTR_VALID,
    output logic            OUT_INSTR_READY,
    output logic [PC_W-1:0] OUT_PC,
    output logic [7:0]      OUT_ALU_A,
    output logic [7:0]      OUT_ALU_R,
    output logic [3:0]      OUT_ALU_OP,
    output logic            OUT_ALU_CY,
    input  logic [7:0]      IN_ALU_A,
    input  logic            IN_ALU_CY,
    output logic [7:0]      OUT_ACC,
    output logic            OUT_CY,
    output logic            OUT_BUSY,
    output logic            OUT_HALTED
);

    state_e          state;
    logic [PC_W-1:0] pc;
    logic [7:0]      acc;
    logic            cy;
    logic [15:0]     instr;
    op_e             op;
    logic [7:0]      rd_data;
    logic            rf_wr_en;
    logic [2:0]      unused_instr_bits;

    assign op                = op_e'(instr[OP_MSB:OP_LSB]);
    assign unused_instr_bits = instr[10:8];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            pc    <= '0;
            acc   <= 8'h00;
            cy    <= 1'b0;
            instr <= NOP_INSTR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_START) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (IN_INSTR_VALID) begin
                        instr <= IN_INSTR;
                        pc    <= pc + PC_W'(1);
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= (op == OP_HALT) ? ST_HALT : ST_FETCH;
                    if (is_alu_op(op)) begin
                        acc <= IN_ALU_A;
                        cy  <= IN_ALU_CY;
                    end else if (op == OP_CLC) begin
                        cy <= 1'b0;
                    end
`ifdef ACC_SEQ_JUMP_EN
                    else if (op == OP_JMP || (op == OP_JC && cy)) begin
                        pc <= PC_W'(instr[7:0]);
                    end
`endif
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The regfile's own sync reset takes priority, so RST during EXEC blocks a ST
    assign rf_wr_en = (state == ST_EXEC) && (op == OP_ST);

    acc_regfile #(.AW(REG_AW)) u_regfile (
        .CLK     (CLK),
        .RST     (RST),
        .rd_addr (instr[REG_AW-1:0]),
        .rd_data (rd_data),
        .wr_en   (rf_wr_en),
        .wr_addr (instr[REG_AW-1:0]),
        .wr_data (acc)
    );

    assign OUT_INSTR_READY = (state == ST_FETCH);
    assign OUT_BUSY        = (state == ST_FETCH) || (state == ST_EXEC);
    assign OUT_HALTED      = (state == ST_HALT);
    assign OUT_PC          = pc;
    assign OUT_ACC         = acc;
    assign OUT_CY          = cy;
    assign OUT_ALU_A       = acc;
    assign OUT_ALU_CY      = cy;
    assign OUT_ALU_OP      = instr[OP_MSB:OP_LSB];
    assign OUT_ALU_R       = instr[IMM_BIT] ? instr[7:0] : rd_data;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: directed vector table, multi-cycle corner sequences, randomized run vs. a reference model.
module tb_acc_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_START;
    logic [15:0] IN_INSTR;
    logic        IN_INSTR_VALID;
    logic        OUT_INSTR_READY;
    logic [7:0]  OUT_PC;
    logic [7:0]  OUT_ALU_A;
    logic [7:0]  OUT_ALU_R;
    logic [3:0]  OUT_ALU_OP;
    logic        OUT_ALU_CY;
    logic [7:0]  IN_ALU_A;
    logic        IN_ALU_CY;
    logic [7:0]  OUT_ACC;
    logic        OUT_CY;
    logic        OUT_BUSY;
    logic        OUT_HALTED;

    int n_pass  = 0;
    int n_total = 0;

    acc_sequencer #(.PC_W(8), .REG_AW(2)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .IN_START        (IN_START),
        .IN_INSTR        (IN_INSTR),
        .IN_INSTR_VALID  (IN_INSTR_VALID),
        .OUT_INSTR_READY (OUT_INSTR_READY),
        .OUT_PC          (OUT_PC),
        .OUT_ALU_A       (OUT_ALU_A),
        .OUT_ALU_R       (OUT_ALU_R),
        .OUT_ALU_OP      (OUT_ALU_OP),
        .OUT_ALU_CY      (OUT_ALU_CY),
        .IN_ALU_A        (IN_ALU_A),
        .IN_ALU_CY       (IN_ALU_CY),
        .OUT_ACC         (OUT_ACC),
        .OUT_CY          (OUT_CY),
        .OUT_BUSY        (OUT_BUSY),
        .OUT_HALTED      (OUT_HALTED)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU: {carry, result}; ADD/SUB chain through the carry/borrow flag
    function automatic logic [8:0] alu_fn(logic [3:0] op, logic [7:0] a, logic [7:0] r, logic c);
        case (op)
            4'h0:    return {1'b0, a} + {1'b0, r} + {8'h00, c};
            4'h1:    return {1'b0, a} - {1'b0, r} - {8'h00, c};
            4'h2:    return {1'b0, a | r};
            4'h3:    return {1'b0, a & r};
            4'h4:    return {1'b0, a ^ r};
            4'h5:    return {1'b0, ~a};
            4'h6:    return {1'b0, r};
            default: return 9'h000;
        endcase
    endfunction

    assign {IN_ALU_CY, IN_ALU_A} = alu_fn(OUT_ALU_OP, OUT_ALU_A, OUT_ALU_R, OUT_ALU_CY);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Transfer one instruction and run its EXEC cycle; returns the ALU operand seen during EXEC
    task automatic xfer(input logic [15:0] ins, output logic [7:0] r_seen);
        int n = 0;
        while (!OUT_INSTR_READY && n < 8) begin
            tick();
            n++;
        end
        chk("fetch_ready", {15'b0, OUT_INSTR_READY}, 16'h0001);
        IN_INSTR       = ins;
        IN_INSTR_VALID = 1'b1;
        tick();
        IN_INSTR_VALID = 1'b0;
        r_seen = OUT_ALU_R;
        tick();
    endtask

    // Reference model state
    logic [7:0] m_acc, m_pc;
    logic       m_cy;
    logic [7:0] m_r [4];

    function automatic logic [7:0] m_operand(logic [15:0] ins);
        return ins[11] ? ins[7:0] : m_r[ins[1:0]];
    endfunction

    task automatic model_reset();
        m_acc = 8'h00; m_pc = 8'h00; m_cy = 1'b0;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    endtask

    task automatic model_exec(input logic [15:0] ins);
        logic [3:0] op = ins[15:12];
        logic [7:0] opnd = m_operand(ins);
        m_pc = m_pc + 8'd1;
        if (op <= 4'h6) {m_cy, m_acc} = alu_fn(op, m_acc, opnd, m_cy);
        else if (op == 4'h7) m_r[ins[1:0]] = m_acc;
        else if (op == 4'h8) m_cy = 1'b0;
`ifdef ACC_SEQ_JUMP_EN
        else if (op == 4'hA || (op == 4'hB && m_cy)) m_pc = ins[7:0];
`endif
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  exp_r;
        logic [7:0]  exp_acc;
        logic        exp_cy;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] r_seen;
    logic [7:0] exp_r;
    logic [15:0] ins;

    initial begin
        vecs[0] = '{16'h6805, 8'h05, 8'h05, 1'b0};
        vecs[1] = '{16'h08FF, 8'hFF, 8'h04, 1'b1};
        vecs[2] = '{16'h0800, 8'h00, 8'h05, 1'b0};
        vecs[3] = '{16'h68AA, 8'hAA, 8'hAA, 1'b0};
        vecs[4] = '{16'h7002, 8'h00, 8'hAA, 1'b0};
        vecs[5] = '{16'h6800, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{16'h2002, 8'hAA, 8'hAA, 1'b0};
        vecs[7] = '{16'h8000, 8'h00, 8'hAA, 1'b0};
        vecs[8] = '{16'h6800, 8'h00, 8'h00, 1'b0};
        vecs[9] = '{16'h1801, 8'h01, 8'hFF, 1'b1};

        RST = 1'b1; IN_START = 1'b0; IN_INSTR = 16'h0000; IN_INSTR_VALID = 1'b0;
        tick(); tick();
        chk("rst_pc",     {8'h00, OUT_PC},             16'h0000);
        chk("rst_acc",    {8'h00, OUT_ACC},            16'h0000);
        chk("rst_cy",     {15'b0, OUT_CY},             16'h0000);
        chk("rst_busy",   {15'b0, OUT_BUSY},           16'h0000);
        chk("rst_halted", {15'b0, OUT_HALTED},         16'h0000);
        chk("rst_ready",  {15'b0, OUT_INSTR_READY},    16'h0000);
        chk("rst_alu_r",  {8'h00, OUT_ALU_R},          16'h0000);
        chk("rst_alu_op", {12'h000, OUT_ALU_OP},       16'h000F);
        RST = 1'b0;

        IN_START = 1'b1; tick(); IN_START = 1'b0;
        chk("start_busy", {15'b0, OUT_BUSY}, 16'h0001);

        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].instr, r_seen);
            chk($sformatf("vec%0d_alu_r", i), {8'h00, r_seen},  {8'h00, vecs[i].exp_r});
            chk($sformatf("vec%0d_acc", i),   {8'h00, OUT_ACC}, {8'h00, vecs[i].exp_acc});
            chk($sformatf("vec%0d_cy", i),    {15'b0, OUT_CY},  {15'b0, vecs[i].exp_cy});
            if (i == 2) chk("pc_after_3", {8'h00, OUT_PC}, 16'h0003);
        end
        chk("pc_after_10", {8'h00, OUT_PC}, 16'h000A);

        // Stall in FETCH with VALID low
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ready", {15'b0, OUT_INSTR_READY}, 16'h0001);
            chk("stall_busy",  {15'b0, OUT_BUSY},        16'h0001);
            chk("stall_pc",    {8'h00, OUT_PC},          16'h000A);
            chk("stall_acc",   {8'h00, OUT_ACC},         16'h00FF);
            chk("stall_cy",    {15'b0, OUT_CY},          16'h0001);
        end
        chk("fetch_alu_op", {12'h000, OUT_ALU_OP}, 16'h0001);
        chk("fetch_alu_a",  {8'h00, OUT_ALU_A},    16'h00FF);

        xfer(16'hB840, r_seen);
`ifdef ACC_SEQ_JUMP_EN
        chk("jc_pc", {8'h00, OUT_PC}, 16'h0040);
`else
        chk("jc_pc", {8'h00, OUT_PC}, 16'h000B);
`endif
        chk("jc_acc", {8'h00, OUT_ACC}, 16'h00FF);

        // Reset during EXEC of ADD #FF: nothing commits
        IN_INSTR = 16'h08FF; IN_INSTR_VALID = 1'b1;
        tick();
        IN_INSTR_VALID = 1'b0;
        chk("exec_busy", {15'b0, OUT_BUSY}, 16'h0001);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rstx_acc",  {8'h00, OUT_ACC},  16'h0000);
        chk("rstx_cy",   {15'b0, OUT_CY},   16'h0000);
        chk("rstx_pc",   {8'h00, OUT_PC},   16'h0000);
        chk("rstx_busy", {15'b0, OUT_BUSY}, 16'h0000);

        // HALT, START ignored, RST recovers
        IN_START = 1'b1; tick(); IN_START = 1'b0;
        xfer(16'h9000, r_seen);
        chk("halt_halted", {15'b0, OUT_HALTED},      16'h0001);
        chk("halt_ready",  {15'b0, OUT_INSTR_READY}, 16'h0000);
        chk("halt_busy",   {15'b0, OUT_BUSY},        16'h0000);
        IN_START = 1'b1; tick(); IN_START = 1'b0; tick();
        chk("halt_start_ign", {15'b0, OUT_HALTED}, 16'h0001);
        chk("halt_pc",        {8'h00, OUT_PC},     16'h0001);
        RST = 1'b1; tick(); RST = 1'b0;
        chk("halt_rst_halted", {15'b0, OUT_HALTED}, 16'h0000);
        chk("halt_rst_pc",     {8'h00, OUT_PC},     16'h0000);
        chk("halt_rst_acc",    {8'h00, OUT_ACC},    16'h0000);

        // Randomized run against the reference model (no HALT), long enough to wrap the PC
        model_reset();
        IN_START = 1'b1; tick(); IN_START = 1'b0;
        for (int k = 0; k < 300; k++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            if (op >= 4'h9) op = op + 4'h1;
            ins = {op, 12'($urandom)};
            repeat ($urandom_range(0, 2)) tick();
            exp_r = m_operand(ins);
            xfer(ins, r_seen);
            model_exec(ins);
            chk("rand_alu_r", {8'h00, r_seen},  {8'h00, exp_r});
            chk("rand_acc",   {8'h00, OUT_ACC}, {8'h00, m_acc});
            chk("rand_cy",    {15'b0, OUT_CY},  {15'b0, m_cy});
            chk("rand_pc",    {8'h00, OUT_PC},  {8'h00, m_pc});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
